axil_csr_bank: RTL

AXI4-lite slave endpoint terminating a master's transactions in a bank of REG_COUNT control/status registers. Sits at the leaf of an AXI-lite interconnect. Drives register contents to fabric logic as a flat vector. Samples status inputs for read-only slots and emits per-register access pulses for side effects such as clear-on-read and doorbells.

---
 rtl/axil_csr_bank_pkg.sv | 12 +
 rtl/axil_csr_bank.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/axil_csr_bank_pkg.sv
// axil_csr_bank_pkg: shared AXI-lite response codes.
// Imported by AXI-lite endpoints such as axil_csr_bank.
package axil_csr_bank_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axil_resp_e;

endpackage

// File: rtl/axil_csr_bank.sv
// axil_csr_bank: AXI-lite slave terminating in REG_COUNT CSRs.
// Ports: clk/rst, s_axil_{aw,w,b,ar,r}* slave channels,
// reg_out (RW values), status_in (RO sources),
// wr_pulse/rd_pulse (one-cycle per-register access strobes).
module axil_csr_bank
  import axil_csr_bank_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int REG_COUNT = 16,
  parameter logic [REG_COUNT-1:0] RO_MASK = '0,
  parameter logic [REG_COUNT*DATA_WIDTH-1:0] REG_RESET = '0
) (
  input  logic clk,
  input  logic rst,

  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,

  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,

  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,

  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,

  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,

  output logic [REG_COUNT*DATA_WIDTH-1:0] reg_out,
  input  logic [REG_COUNT*DATA_WIDTH-1:0] status_in,
  output logic [REG_COUNT-1:0]            wr_pulse,
  output logic [REG_COUNT-1:0]            rd_pulse
);

  localparam int OFFS = $clog2(STRB_WIDTH);
  localparam int IDXW = ADDR_WIDTH - OFFS;

  logic                  aw_full;
  logic                  w_full;
  logic [IDXW-1:0]       aw_idx;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0] w_strb;

  logic [IDXW-1:0]       ar_idx;
  logic [REG_COUNT-1:0]  aw_sel;
  logic [REG_COUNT-1:0]  ar_sel;
  logic [DATA_WIDTH-1:0] ar_mux;
  logic [1:0]            wr_resp;

  logic commit;
  logic aw_fire;
  logic w_fire;
  logic ar_fire;

  logic unused_bits;
  assign unused_bits = ^{s_axil_awprot, s_axil_arprot,
                         s_axil_awaddr[OFFS-1:0],
                         s_axil_araddr[OFFS-1:0],
                         status_in};

  assign ar_idx = s_axil_araddr[ADDR_WIDTH-1:OFFS];

  // A held B response blocks the join; bready frees it
  // on the same edge so back-to-back writes stream.
  assign commit = aw_full && w_full &&
                  (!s_axil_bvalid || s_axil_bready);

  // A full slot that commits this edge can refill at once.
  assign s_axil_awready = !rst && (!aw_full || commit);
  assign s_axil_wready  = !rst && (!w_full || commit);
  assign s_axil_arready = !rst && !s_axil_rvalid;

  assign aw_fire = s_axil_awvalid && s_axil_awready;
  assign w_fire  = s_axil_wvalid && s_axil_wready;
  assign ar_fire = s_axil_arvalid && s_axil_arready;

  // Out-of-range indices select nothing, which is what
  // yields DECERR, zero read data and no pulse.
  always_comb begin
    aw_sel = '0;
    ar_sel = '0;
    ar_mux = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      aw_sel[i] = (aw_idx == IDXW'(i));
      ar_sel[i] = (ar_idx == IDXW'(i));
      if (ar_idx == IDXW'(i)) begin
        ar_mux = RO_MASK[i]
               ? status_in[i*DATA_WIDTH +: DATA_WIDTH]
               : reg_out[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    wr_resp = RESP_OKAY;
    if (~|aw_sel) begin
      wr_resp = RESP_DECERR;
    end else if (|(aw_sel & RO_MASK)) begin
      wr_resp = RESP_SLVERR;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_full       <= 1'b0;
      w_full        <= 1'b0;
      aw_idx        <= '0;
      w_data        <= '0;
      w_strb        <= '0;
      s_axil_bvalid <= 1'b0;
      s_axil_bresp  <= RESP_OKAY;
      wr_pulse      <= '0;
      reg_out       <= REG_RESET;
    end else begin
      wr_pulse <= '0;
      if (s_axil_bvalid && s_axil_bready) begin
        s_axil_bvalid <= 1'b0;
      end
      if (commit) begin
        s_axil_bvalid <= 1'b1;
        s_axil_bresp  <= wr_resp;
        wr_pulse      <= aw_sel & ~RO_MASK;
        aw_full       <= 1'b0;
        w_full        <= 1'b0;
        for (int i = 0; i < REG_COUNT; i++) begin
          for (int b = 0; b < STRB_WIDTH; b++) begin
            if (aw_sel[i] && !RO_MASK[i] && w_strb[b]) begin
              reg_out[i*DATA_WIDTH + b*8 +: 8] <=
                w_data[b*8 +: 8];
            end
          end
        end
      end
      // Capture after commit so a refill on the commit
      // edge leaves the slot full.
      if (aw_fire) begin
        aw_full <= 1'b1;
        aw_idx  <= s_axil_awaddr[ADDR_WIDTH-1:OFFS];
      end
      if (w_fire) begin
        w_full <= 1'b1;
        w_data <= s_axil_wdata;
        w_strb <= s_axil_wstrb;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_axil_rvalid <= 1'b0;
      s_axil_rdata  <= '0;
      s_axil_rresp  <= RESP_OKAY;
      rd_pulse      <= '0;
    end else begin
      rd_pulse <= '0;
      if (s_axil_rvalid && s_axil_rready) begin
        s_axil_rvalid <= 1'b0;
      end
      if (ar_fire) begin
        s_axil_rvalid <= 1'b1;
        s_axil_rdata  <= ar_mux;
        s_axil_rresp  <= (|ar_sel) ? RESP_OKAY : RESP_DECERR;
        rd_pulse      <= ar_sel;
      end
    end
  end

endmodule
